// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: opcodes, FSM state encoding and instruction field positions
// shared by the rf_seq_ctrl sequencer and its decoder.
package rf_seq_pkg;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_MVI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field slice positions within the fetched word
  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 2;
  localparam int RS_HI = 1;
  localparam int RS_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_READ,
    S_WAIT_RF,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/rf_seq_decode.sv
// rf_seq_decode: combinational opcode classifier used by the sequencer's
// DECODE, FETCH_IMM and WAIT_RF steps.
module rf_seq_decode
  import rf_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic       needs_imm,
  output logic       needs_read,
  output logic       writes_rd,
  output logic       is_branch,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    needs_imm  = 1'b0;
    needs_read = 1'b0;
    writes_rd  = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_MOV, OP_ADD, OP_SUB: begin
        needs_read = 1'b1;
        writes_rd  = 1'b1;
      end
      OP_MVI: begin
        needs_imm = 1'b1;
        writes_rd = 1'b1;
      end
      OP_JMP: begin
        needs_imm = 1'b1;
        is_branch = 1'b1;
      end
      // JZ needs both the target word and the register value it tests
      OP_JZ: begin
        needs_imm  = 1'b1;
        needs_read = 1'b1;
        is_branch  = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: multi-cycle control sequencer for the 4-entry register group.
// Optional macro RF_SEQ_ILLEGAL_TRAP_EN: undefined opcodes halt with err=1 (otherwise NOP).
module rf_seq_ctrl
  import rf_seq_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [AW-1:0]     imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [1:0]        rf_rd,
  output logic [1:0]        rf_rs,
  output logic              rf_en_in,
  input  logic [DWIDTH-1:0] rf_rd_q,
  input  logic [DWIDTH-1:0] rf_rs_q,
  input  logic              rf_valid,
  output logic [3:0]        rf_reg_en,
  output logic [DWIDTH-1:0] rf_d,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  state_t            state;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     imm;
  logic [7:0]        ir;
  logic [DWIDTH-1:0] alu_result;
  logic              dec_needs_imm, dec_needs_read, dec_writes_rd;
  logic              dec_is_branch, dec_is_halt, dec_illegal;

  rf_seq_decode u_decode (
    .op         (ir[OP_HI:OP_LO]),
    .needs_imm  (dec_needs_imm),
    .needs_read (dec_needs_read),
    .writes_rd  (dec_writes_rd),
    .is_branch  (dec_is_branch),
    .is_halt    (dec_is_halt),
    .illegal    (dec_illegal)
  );

  assign imem_addr = pc;

  always_comb begin
    alu_result = rf_rs_q;
    case (ir[OP_HI:OP_LO])
      OP_ADD:  alu_result = rf_rd_q + rf_rs_q;
      OP_SUB:  alu_result = rf_rd_q - rf_rs_q;
      default: alu_result = rf_rs_q;
    endcase
  end

`ifndef RF_SEQ_ILLEGAL_TRAP_EN
  assign err = 1'b0;
`endif

  // Strobes (rf_en_in, rf_reg_en, rf_d) default low and are raised on the edge entering their state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      imm       <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      rf_rd     <= 2'b00;
      rf_rs     <= 2'b00;
      rf_en_in  <= 1'b0;
      rf_reg_en <= 4'b0000;
      rf_d      <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
      err       <= 1'b0;
`endif
    end else begin
      rf_en_in  <= 1'b0;
      rf_reg_en <= 4'b0000;
      rf_d      <= '0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= '0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
            err      <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata[7:0];
            pc       <= pc + AW'(1);
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else if (dec_needs_imm) begin
            state    <= S_FETCH_IMM;
            imem_req <= 1'b1;
          end else if (dec_needs_read) begin
            state    <= S_READ;
            rf_en_in <= 1'b1;
            rf_rd    <= ir[RD_HI:RD_LO];
            rf_rs    <= ir[RS_HI:RS_LO];
          end else if (dec_illegal) begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
            state  <= S_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
            err    <= 1'b1;
`else
            state    <= S_FETCH;
            imem_req <= 1'b1;
`endif
          end
        end
        S_FETCH_IMM: begin
          if (imem_ack) begin
            imm      <= imem_rdata[AW-1:0];
            pc       <= pc + AW'(1);
            imem_req <= 1'b0;
            if (dec_writes_rd) begin
              state     <= S_WB;
              rf_reg_en <= 4'b0001 << ir[RD_HI:RD_LO];
              rf_d      <= imem_rdata;
            end else if (dec_needs_read) begin
              state    <= S_READ;
              rf_en_in <= 1'b1;
              rf_rd    <= ir[RD_HI:RD_LO];
              rf_rs    <= ir[RS_HI:RS_LO];
            end else begin
              // JMP: target overrides the incremented pc; request stays up for the next fetch
              pc       <= imem_rdata[AW-1:0];
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_READ: state <= S_WAIT_RF;
        S_WAIT_RF: begin
          if (rf_valid) begin
            if (dec_is_branch) begin
              if (rf_rd_q == '0) pc <= imm;
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state     <= S_WB;
              rf_reg_en <= 4'b0001 << ir[RD_HI:RD_LO];
              rf_d      <= alu_result;
            end
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: directed and randomized checks of rf_seq_ctrl against an
// instruction-level interpreter, with behavioural imem and register-group models.
`timescale 1ns/1ps
module tb_rf_seq_ctrl;
  localparam int DWIDTH = 16;
  localparam int AW     = 8;
  localparam logic [15:0] W_HALT = 16'h00F0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic              imem_ack = 1'b0;
  logic [DWIDTH-1:0] imem_rdata = '0;
  logic [1:0]        rf_rd, rf_rs;
  logic              rf_en_in;
  logic [DWIDTH-1:0] rf_rd_q = '0, rf_rs_q = '0;
  logic              rf_valid = 1'b0;
  logic [3:0]        rf_reg_en;
  logic [DWIDTH-1:0] rf_d;
  logic              busy, halted, err;

  rf_seq_ctrl #(.DWIDTH(DWIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_rd(rf_rd), .rf_rs(rf_rs), .rf_en_in(rf_en_in),
    .rf_rd_q(rf_rd_q), .rf_rs_q(rf_rs_q), .rf_valid(rf_valid),
    .rf_reg_en(rf_reg_en), .rf_d(rf_d), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] en; logic [DWIDTH-1:0] d; int cyc; } wr_t;
  typedef struct { logic [AW-1:0] addr; int cyc; } fe_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DWIDTH-1:0] mem [256];
  logic [DWIDTH-1:0] init_regs [4];
  int  ack_wait = 0;
  int  cyc = 0;
  int  wait_cycles = 0;
  int  addr_slips = 0;
  wr_t wr_q[$];
  fe_t fe_q[$];

  logic [3:0]        exp_wr_en[$];
  logic [DWIDTH-1:0] exp_wr_d[$];
  logic [AW-1:0]     exp_fe[$];
  logic              exp_err;

  // Environment: imem responder with programmable wait, register group with registered en_out
  initial begin : env
    int wcnt;
    logic s_en, was_waiting;
    logic [1:0] s_rd, s_rs;
    logic [3:0] s_wen;
    logic [DWIDTH-1:0] s_d;
    logic [DWIDTH-1:0] regs [4];
    logic [AW-1:0] last_addr;
    wcnt = 0; s_en = 0; was_waiting = 0; s_rd = 0; s_rs = 0; s_wen = 0; s_d = 0; last_addr = 0;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      s_en = rf_en_in; s_rd = rf_rd; s_rs = rf_rs; s_wen = rf_reg_en; s_d = rf_d;
      if (rst_n && rf_reg_en != 4'b0000) wr_q.push_back('{rf_reg_en, rf_d, cyc});
      if (rst_n && imem_req && imem_ack) fe_q.push_back('{imem_addr, cyc});
      if (rst_n && imem_req && !imem_ack) wait_cycles++;
      if (rst_n && imem_req && was_waiting && imem_addr != last_addr) addr_slips++;
      was_waiting = rst_n && imem_req && !imem_ack;
      last_addr = imem_addr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        imem_ack = 1'b0; rf_valid = 1'b0; wcnt = 0;
        for (int i = 0; i < 4; i++) regs[i] = init_regs[i];
      end else begin
        for (int i = 0; i < 4; i++) if (s_wen[i]) regs[i] = s_d;
        rf_valid = s_en;
        if (s_en) begin
          rf_rd_q = regs[s_rd];
          rf_rs_q = regs[s_rs];
        end
        if (imem_req) begin
          if (wcnt >= ack_wait) begin
            imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wcnt = 0;
          end else begin
            imem_ack = 1'b0; wcnt++;
          end
        end else begin
          imem_ack = 1'b0; wcnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction-level interpreter: expected fetch addresses and register writes
  function automatic void model_run();
    logic [DWIDTH-1:0] r [4];
    logic [DWIDTH-1:0] w, imm;
    logic [3:0] op;
    int pc, rd, rs;
    for (int i = 0; i < 4; i++) r[i] = init_regs[i];
    exp_fe.delete(); exp_wr_en.delete(); exp_wr_d.delete();
    exp_err = 1'b0;
    pc = 0;
    imm = '0;
    for (int step = 0; step < 1000; step++) begin
      w = mem[pc];
      exp_fe.push_back(AW'(pc));
      pc = (pc + 1) % 256;
      op = w[7:4]; rd = int'(w[3:2]); rs = int'(w[1:0]);
      if (op == 4'h1 || op == 4'h4 || op == 4'h5) begin
        imm = mem[pc];
        exp_fe.push_back(AW'(pc));
        pc = (pc + 1) % 256;
      end
      case (op)
        4'h0: r[rd] = r[rs];
        4'h1: r[rd] = imm;
        4'h2: r[rd] = r[rd] + r[rs];
        4'h3: r[rd] = r[rd] - r[rs];
        4'h4: pc = int'(imm) % 256;
        4'h5: if (r[rd] == 0) pc = int'(imm) % 256;
        4'hF: return;
        default: begin
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
          exp_err = 1'b1;
          return;
`endif
        end
      endcase
      if (op <= 4'h3) begin
        exp_wr_en.push_back(4'(1 << rd));
        exp_wr_d.push_back(r[rd]);
      end
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = W_HALT;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int limit, output bit ok);
    ok = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (halted) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [DWIDTH+AW+8:0] obs;
    for (int i = 0; i < 4; i++) init_regs[i] = '0;
    clear_mem();
    do_reset();
    obs = {imem_req, busy, halted, err, rf_en_in, rf_reg_en, rf_d, imem_addr};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit found;
    int base;
    clear_mem();
    mem[0] = 16'h0014; mem[1] = 16'h0005; mem[2] = 16'h0026;
    ack_wait = 0;
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rf_reg_en != 4'b0000) begin ack_wait = 50; found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("[TB] FAIL mid_fetch_setup: got no write expected MVI write"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h02}) begin
      n_fail++;
      $display("[TB] FAIL mid_fetch_req: got req=%b addr=%h expected req=1 addr=02", imem_req, imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, busy, imem_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got req=%b busy=%b addr=%h expected 0 0 00", imem_req, busy, imem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_wait = 0;
    base = wr_q.size();
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_q.size() != base || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got writes=%0d busy=%b expected 0 0", wr_q.size() - base, busy);
    end
  endtask

  task automatic test_alu();
    bit ok;
    int wb, fb, add_cyc;
    clear_mem();
    mem[0] = 16'h0014; mem[1] = 16'h0005;
    mem[2] = 16'h0018; mem[3] = 16'h0003;
    mem[4] = 16'h0026; mem[5] = 16'h0039;
    for (int i = 0; i < 4; i++) init_regs[i] = '0;
    ack_wait = 0;
    do_reset();
    wb = wr_q.size(); fb = fe_q.size();
    run_until_halt(200, ok);
    n_checks++;
    if (!ok || wr_q.size() - wb != 4) begin
      n_fail++;
      $display("[TB] FAIL alu_writes: got halted=%b writes=%0d expected 1 4", ok, wr_q.size() - wb);
    end else begin
      n_checks++;
      if ({wr_q[wb].en, wr_q[wb].d, wr_q[wb+1].en, wr_q[wb+1].d} !== {4'b0010, 16'h0005, 4'b0100, 16'h0003}) begin
        n_fail++;
        $display("[TB] FAIL mvi_writes: got %b/%h %b/%h expected 0010/0005 0100/0003",
                 wr_q[wb].en, wr_q[wb].d, wr_q[wb+1].en, wr_q[wb+1].d);
      end
      n_checks++;
      if ({wr_q[wb+2].en, wr_q[wb+2].d} !== {4'b0010, 16'h0008}) begin
        n_fail++;
        $display("[TB] FAIL add_write: got %b/%h expected 0010/0008", wr_q[wb+2].en, wr_q[wb+2].d);
      end
      n_checks++;
      if ({wr_q[wb+3].en, wr_q[wb+3].d} !== {4'b0100, 16'hFFFB}) begin
        n_fail++;
        $display("[TB] FAIL sub_wrap: got %b/%h expected 0100/fffb", wr_q[wb+3].en, wr_q[wb+3].d);
      end
      // ADD occupies 5 cycles: the write-back is the 5th counting the ack cycle
      add_cyc = -100;
      for (int i = fb; i < fe_q.size(); i++) if (fe_q[i].addr == 8'h04) add_cyc = fe_q[i].cyc;
      n_checks++;
      if (wr_q[wb+2].cyc - add_cyc != 4) begin
        n_fail++;
        $display("[TB] FAIL add_latency: got %0d cycles after ack expected 4", wr_q[wb+2].cyc - add_cyc);
      end
    end
  endtask

  task automatic test_jz();
    bit ok;
    int fb;
    // Taken: SUB r3,r3 zeroes r3, JZ lands at 0x20
    clear_mem();
    mem[0] = 16'h003F; mem[1] = 16'h005C; mem[2] = 16'h0020;
    init_regs[3] = 16'h1234;
    ack_wait = 0;
    do_reset();
    fb = fe_q.size();
    run_until_halt(200, ok);
    n_checks++;
    if (!ok || fe_q.size() - fb != 4) begin
      n_fail++;
      $display("[TB] FAIL jz_taken_count: got halted=%b fetches=%0d expected 1 4", ok, fe_q.size() - fb);
    end else if (fe_q[fb+3].addr !== 8'h20) begin
      n_fail++;
      $display("[TB] FAIL jz_taken_target: got %h expected 20", fe_q[fb+3].addr);
    end
    // Not taken: r3=1, fall through to JZ address + 2
    clear_mem();
    mem[0] = 16'h001C; mem[1] = 16'h0001; mem[2] = 16'h005C; mem[3] = 16'h0020;
    mem[8'h20] = 16'h0014;
    do_reset();
    fb = fe_q.size();
    run_until_halt(200, ok);
    n_checks++;
    if (!ok || fe_q.size() - fb != 5) begin
      n_fail++;
      $display("[TB] FAIL jz_fall_count: got halted=%b fetches=%0d expected 1 5", ok, fe_q.size() - fb);
    end else if (fe_q[fb+4].addr !== 8'h04) begin
      n_fail++;
      $display("[TB] FAIL jz_fall_target: got %h expected 04", fe_q[fb+4].addr);
    end
  endtask

  task automatic test_jmp_wrap();
    bit ok;
    int fb, wb, w0, s0;
    logic [AW-1:0] exp_addr [5];
    exp_addr[0] = 8'h00; exp_addr[1] = 8'h01; exp_addr[2] = 8'hFE;
    exp_addr[3] = 8'hFF; exp_addr[4] = 8'hFF;
    clear_mem();
    mem[0] = 16'h0040; mem[1] = 16'h00FE;
    mem[8'hFE] = 16'h0040; mem[8'hFF] = 16'h00FF;
    ack_wait = 3;
    do_reset();
    fb = fe_q.size(); wb = wr_q.size(); w0 = wait_cycles; s0 = addr_slips;
    run_until_halt(300, ok);
    n_checks++;
    if (!ok || fe_q.size() - fb != 5) begin
      n_fail++;
      $display("[TB] FAIL jmp_wrap_count: got halted=%b fetches=%0d expected 1 5", ok, fe_q.size() - fb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (fe_q[fb+i].addr !== exp_addr[i]) begin
          n_fail++;
          $display("[TB] FAIL jmp_wrap_addr[%0d]: got %h expected %h", i, fe_q[fb+i].addr, exp_addr[i]);
        end
      end
    end
    n_checks++;
    if (wait_cycles - w0 != 15 || addr_slips != s0 || wr_q.size() != wb) begin
      n_fail++;
      $display("[TB] FAIL ack_wait_hold: got waits=%0d slips=%0d writes=%0d expected 15 0 0",
               wait_cycles - w0, addr_slips - s0, wr_q.size() - wb);
    end
    ack_wait = 0;
  endtask

  task automatic test_illegal();
    bit ok;
    int fb, wb;
    clear_mem();
    mem[0] = 16'h12A5; mem[1] = 16'h0010; mem[2] = 16'h1234;
    ack_wait = 0;
    do_reset();
    fb = fe_q.size(); wb = wr_q.size();
    run_until_halt(200, ok);
`ifdef RF_SEQ_ILLEGAL_TRAP_EN
    n_checks++;
    if (!ok || err !== 1'b1 || fe_q.size() - fb != 1 || wr_q.size() != wb) begin
      n_fail++;
      $display("[TB] FAIL illegal_trap: got halted=%b err=%b fetches=%0d writes=%0d expected 1 1 1 0",
               ok, err, fe_q.size() - fb, wr_q.size() - wb);
    end
`else
    n_checks++;
    if (!ok || err !== 1'b0 || fe_q.size() - fb != 4 || wr_q.size() - wb != 1) begin
      n_fail++;
      $display("[TB] FAIL illegal_nop: got halted=%b err=%b fetches=%0d writes=%0d expected 1 0 4 1",
               ok, err, fe_q.size() - fb, wr_q.size() - wb);
    end else if (fe_q[fb+1].addr !== 8'h01 || {wr_q[wb].en, wr_q[wb].d} !== {4'b0001, 16'h1234}) begin
      n_fail++;
      $display("[TB] FAIL illegal_nop_flow: got addr=%h write=%b/%h expected 01 0001/1234",
               fe_q[fb+1].addr, wr_q[wb].en, wr_q[wb].d);
    end
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr, busy, halted, err} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL restart: got req=%b addr=%h busy=%b halted=%b err=%b expected 1 00 1 0 0",
               imem_req, imem_addr, busy, halted, err);
    end
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    int fb, wb, addr, nst, njmp, k, first;
    int starts [64];
    int jpos [64];
    logic [DWIDTH-1:0] w;
    logic [3:0] op;
    for (int iter = 0; iter < 8; iter++) begin
      clear_mem();
      for (int i = 0; i < 4; i++) init_regs[i] = DWIDTH'($urandom);
      ack_wait = int'($urandom_range(0, 2));
      addr = 0; nst = 0; njmp = 0;
      while (addr < 40) begin
        starts[nst] = addr; nst++;
        op = 4'($urandom_range(0, 5));
        w = DWIDTH'($urandom);
        w[7:4] = op;
        mem[addr] = w; addr++;
        if (op == 4'h1 || op == 4'h4 || op == 4'h5) begin
          mem[addr] = DWIDTH'($urandom);
          if (op != 4'h1) begin jpos[njmp] = addr; njmp++; end
          addr++;
        end
      end
      starts[nst] = addr; nst++;
      // Forward-only branch targets on instruction boundaries keep every program finite
      for (int j = 0; j < njmp; j++) begin
        first = nst - 1;
        for (int s = nst - 1; s >= 0; s--) if (starts[s] > jpos[j]) first = s;
        k = int'($urandom_range(first, nst - 1));
        w = DWIDTH'($urandom);
        w[7:0] = 8'(starts[k]);
        mem[jpos[j]] = w;
      end
      model_run();
      do_reset();
      fb = fe_q.size(); wb = wr_q.size();
      run_until_halt(2000, ok);
      n_checks++;
      if (!ok || fe_q.size() - fb != exp_fe.size() || wr_q.size() - wb != exp_wr_en.size()) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_counts: got halted=%b fetches=%0d writes=%0d expected 1 %0d %0d",
                 iter, ok, fe_q.size() - fb, wr_q.size() - wb, exp_fe.size(), exp_wr_en.size());
      end else begin
        for (int i = 0; i < exp_fe.size(); i++) begin
          n_checks++;
          if (fe_q[fb+i].addr !== exp_fe[i]) begin
            n_fail++;
            $display("[TB] FAIL rand%0d_fetch[%0d]: got %h expected %h", iter, i, fe_q[fb+i].addr, exp_fe[i]);
          end
        end
        for (int i = 0; i < exp_wr_en.size(); i++) begin
          n_checks++;
          if ({wr_q[wb+i].en, wr_q[wb+i].d} !== {exp_wr_en[i], exp_wr_d[i]}) begin
            n_fail++;
            $display("[TB] FAIL rand%0d_write[%0d]: got %b/%h expected %b/%h",
                     iter, i, wr_q[wb+i].en, wr_q[wb+i].d, exp_wr_en[i], exp_wr_d[i]);
          end
        end
      end
      n_checks++;
      if (err !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_err: got %b expected %b", iter, err, exp_err);
      end
    end
    ack_wait = 0;
  endtask

  initial begin : main
    for (int i = 0; i < 4; i++) init_regs[i] = '0;
    test_reset();
    test_reset_mid_fetch();
    test_alu();
    test_jz();
    test_jmp_wrap();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
